multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameters: none; all encodings fixed by this document.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 op  input  7  opcode, instruction-register bits [6:0].
REQ-005 funct3  input  3  instruction-register bits [14:12].
REQ-006 funct7b5  input  1  instruction-register bit 30.
REQ-007 zero  input  1  ALU zero flag, current cycle.
REQ-008 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each  PC enable, memory-address select (0=PC, 1=ALUOut), data-memory write, IR enable, register-file write.
REQ-009 ResultSrc  output  2  result mux: 00=ALUOut, 01=read data, 10=ALUResult.
REQ-010 ALUSrcA  output  2  00=PC, 01=OldPC, 10=rs1.
REQ-011 ALUSrcB  output  2  00=rs2, 01=ImmExt, 10=constant 4.
REQ-012 ImmSrc  output  2  immediate-format select to sign extender: 00=I, 01=S, 10=B, 11=J.
REQ-013 ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-014 illegal  output  1  one-cycle pulse on unsupported opcode or branch funct3.
REQ-015 state  output  4  current FSM state code (debug).

Function
REQ-016 Moore FSM; codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, ILLEGAL=11; codes 12-15 return to FETCH next cycle, all outputs 0.
REQ-017 Transitions: FETCH->DECODE; DECODE by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, any other (incl. LUI/AUIPC/JALR)->ILLEGAL.
REQ-018 MEMADR->MEMREAD (op=0000011) else MEMWRITE; MEMREAD->MEMWB; EXECR/EXECI/JAL->ALUWB; MEMWB, MEMWRITE, ALUWB, BRANCH, ILLEGAL->FETCH.
REQ-019 Per-state outputs; unlisted signals 0: FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PC update, ALUOp=add. DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=add. MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=add. MEMREAD: AdrSrc=1. MEMWB: ResultSrc=01, RegWrite=1. MEMWRITE: AdrSrc=1, MemWrite=1. EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=funct. EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct. ALUWB: RegWrite=1. BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=sub. JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=add, PC update. ILLEGAL: illegal=1.
REQ-020 PCWrite = PC update | (state=BRANCH & taken); taken = zero for funct3=000, ~zero for funct3=001.
REQ-021 In DECODE, branch funct3 not 000/001 -> ILLEGAL instead of BRANCH; no PCWrite.
REQ-022 ImmSrc combinational from op in every state: 0100011->01, 1100011->10, 1101111->11, else 00.
REQ-023 ALUOp=funct decode: funct3 000 -> sub if (op[5] & funct7b5) else add; 010->slt; 110->or; 111->and; other funct3->add.
REQ-024 Latency from FETCH entry to next FETCH: lw 5, sw 4, R/I 4, branch 3, jal 4, illegal 3 cycles.
REQ-025 Inputs sampled only when needed: op/funct3 in DECODE, MEMADR, EXEC*, BRANCH; zero only in BRANCH.

Reset
REQ-026 rst_n low at a rising edge: state<=FETCH irrespective of current state, including mid-instruction.
REQ-027 While rst_n low: PCWrite, MemWrite, IRWrite, RegWrite, illegal forced 0 combinationally; other outputs follow FETCH values.
REQ-028 First cycle with rst_n high: FETCH outputs active (IRWrite=1, PCWrite=1).

Verification
REQ-029 lw (op=0000011): state 0,1,2,3,4,0; RegWrite=1 with ResultSrc=01 only in cycle 5; ImmSrc=00.
REQ-030 sw (op=0100011): state 0,1,2,5,0; MemWrite=1, AdrSrc=1 only in MEMWRITE; ImmSrc=01; RegWrite never 1.
REQ-031 sub (op=0110011, funct3=000, funct7b5=1): ALUControl=001 in EXECR; and, or, slt give 010, 011, 101; addi with funct7b5=1 gives 000.
REQ-032 beq zero=1 -> PCWrite=1 in BRANCH; zero=0 -> 0; bne inverts; funct3=100 -> ILLEGAL, illegal pulse, PCWrite 0.
REQ-033 jal (op=1101111): states 0,1,10,8,0; ImmSrc=11; PCWrite=1 in JAL; RegWrite=1 in ALUWB.
REQ-034 rst_n low during MEMREAD: next state FETCH, no MemWB write; write enables 0 while low; op=0110111 -> ILLEGAL pulse, back to FETCH.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Handshake bundle between the multicycle datapath and its control FSM.
// master = datapath side (drives decode fields / zero), slave = controller.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       illegal;
  logic [3:0] state;

  modport master (
    output op, funct3, funct7b5, zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, state
  );

  modport slave (
    input  op, funct3, funct7b5, zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle RV32 subset (lw/sw/R/I/beq/bne/jal).
// Illegal opcodes and unsupported branch conditions take a one-cycle ILLEGAL detour.
module multicycle_ctrl (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.slave  bus
);
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_ILLEGAL  = 4'd11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic [3:0] w_eff_state;
  logic       w_branch_ok;
  logic       w_taken;
  logic [2:0] w_alu_funct;
  logic       w_pc_update;
  logic       w_pcwrite_raw;
  logic       w_memwrite_raw;
  logic       w_irwrite_raw;
  logic       w_regwrite_raw;
  logic       w_illegal_raw;

  assign w_branch_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001);

  always_comb begin
    w_taken = 1'b0;
    if (bus.funct3 == 3'b000)      w_taken = bus.zero;
    else if (bus.funct3 == 3'b001) w_taken = ~bus.zero;
  end

  // funct7b5 only selects sub for register-register ops (op[5]); addi ignores it
  always_comb begin
    w_alu_funct = ALU_ADD;
    case (bus.funct3)
      3'b000:  w_alu_funct = (bus.op[5] & bus.funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  w_alu_funct = ALU_SLT;
      3'b110:  w_alu_funct = ALU_OR;
      3'b111:  w_alu_funct = ALU_AND;
      default: w_alu_funct = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
          OP_RTYPE:          w_next_state = S_EXECR;
          OP_ITYPE:          w_next_state = S_EXECI;
          OP_BRANCH:         w_next_state = w_branch_ok ? S_BRANCH : S_ILLEGAL;
          OP_JAL:            w_next_state = S_JAL;
          default:           w_next_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  w_next_state = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: w_next_state = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL: w_next_state = S_ALUWB;
      default:   w_next_state = S_FETCH;
    endcase
  end

  // While held in reset the outputs mirror FETCH, with every write enable masked
  assign w_eff_state = rst_n ? r_state : S_FETCH;

  always_comb begin
    w_pc_update    = 1'b0;
    w_memwrite_raw = 1'b0;
    w_irwrite_raw  = 1'b0;
    w_regwrite_raw = 1'b0;
    w_illegal_raw  = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ALUControl = ALU_ADD;
    case (w_eff_state)
      S_FETCH: begin
        w_irwrite_raw = 1'b1;
        w_pc_update   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      S_DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
      end
      S_MEMREAD: bus.AdrSrc = 1'b1;
      S_MEMWB: begin
        bus.ResultSrc  = 2'b01;
        w_regwrite_raw = 1'b1;
      end
      S_MEMWRITE: begin
        bus.AdrSrc     = 1'b1;
        w_memwrite_raw = 1'b1;
      end
      S_EXECR: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = w_alu_funct;
      end
      S_EXECI: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = w_alu_funct;
      end
      S_ALUWB:  w_regwrite_raw = 1'b1;
      S_BRANCH: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = ALU_SUB;
      end
      S_JAL: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        w_pc_update = 1'b1;
      end
      S_ILLEGAL: w_illegal_raw = 1'b1;
      default: ;
    endcase
  end

  assign w_pcwrite_raw = w_pc_update | ((w_eff_state == S_BRANCH) & w_taken);

  assign bus.PCWrite  = rst_n & w_pcwrite_raw;
  assign bus.MemWrite = rst_n & w_memwrite_raw;
  assign bus.IRWrite  = rst_n & w_irwrite_raw;
  assign bus.RegWrite = rst_n & w_regwrite_raw;
  assign bus.illegal  = rst_n & w_illegal_raw;
  assign bus.state    = w_eff_state;

  always_comb begin
    case (bus.op)
      OP_STORE:  bus.ImmSrc = 2'b01;
      OP_BRANCH: bus.ImmSrc = 2'b10;
      OP_JAL:    bus.ImmSrc = 2'b11;
      default:   bus.ImmSrc = 2'b00;
    endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: expected per-cycle output vectors are queued
// when an instruction is launched and popped/compared one per cycle.
module tb_multicycle_ctrl;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [20:0] exp_q[$];
  logic [20:0] w_obs;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign w_obs = {bus.state, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
                  bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc,
                  bus.ALUControl, bus.illegal};

  // Reference table of Moore outputs per state, plus the reset masking rule
  function automatic logic [20:0] exp_out(input logic [3:0] st, input logic [6:0] op,
                                          input logic [2:0] f3, input logic f7,
                                          input logic z, input logic rst_low);
    logic       pcw, adr, mw, irw, rw, ill;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] alu, aluf;
    logic [3:0] s;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    res = 0; sa = 0; sb = 0; alu = 3'b000;
    s = rst_low ? 4'd0 : st;
    if (op == 7'b0100011)      imm = 2'b01;
    else if (op == 7'b1100011) imm = 2'b10;
    else if (op == 7'b1101111) imm = 2'b11;
    else                       imm = 2'b00;
    if (f3 == 3'b000)      aluf = (op[5] && f7) ? 3'b001 : 3'b000;
    else if (f3 == 3'b010) aluf = 3'b101;
    else if (f3 == 3'b110) aluf = 3'b011;
    else if (f3 == 3'b111) aluf = 3'b010;
    else                   aluf = 3'b000;
    case (s)
      4'd0:  begin irw = 1; pcw = 1; sb = 2'b10; res = 2'b10; end
      4'd1:  begin sa = 2'b01; sb = 2'b01; end
      4'd2:  begin sa = 2'b10; sb = 2'b01; end
      4'd3:  adr = 1;
      4'd4:  begin res = 2'b01; rw = 1; end
      4'd5:  begin adr = 1; mw = 1; end
      4'd6:  begin sa = 2'b10; alu = aluf; end
      4'd7:  begin sa = 2'b10; sb = 2'b01; alu = aluf; end
      4'd8:  rw = 1;
      4'd9:  begin sa = 2'b10; alu = 3'b001;
                   pcw = (f3 == 3'b000) ? z : ((f3 == 3'b001) ? ~z : 1'b0); end
      4'd10: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      4'd11: ill = 1;
      default: ;
    endcase
    if (rst_low) begin pcw = 0; mw = 0; irw = 0; rw = 0; ill = 0; end
    return {s, pcw, adr, mw, irw, rw, res, sa, sb, imm, alu, ill};
  endfunction

  task automatic check(input string tag);
    logic [20:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: observed=%h expected=<empty scoreboard>", tag, w_obs);
    end else begin
      e = exp_q.pop_front();
      assert (w_obs === e) else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", tag, w_obs, e);
      end
    end
  endtask

  // Launch one instruction from FETCH, queue its expected cycles, then check each cycle
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic z);
    int seq[$];
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
    case (op)
      7'b0000011: seq = '{0, 1, 2, 3, 4};
      7'b0100011: seq = '{0, 1, 2, 5};
      7'b0110011: seq = '{0, 1, 6, 8};
      7'b0010011: seq = '{0, 1, 7, 8};
      7'b1100011: seq = (f3 == 3'b000 || f3 == 3'b001) ? '{0, 1, 9} : '{0, 1, 11};
      7'b1101111: seq = '{0, 1, 10, 8};
      default:    seq = '{0, 1, 11};
    endcase
    foreach (seq[k]) exp_q.push_back(exp_out(4'(seq[k]), op, f3, f7, z, 1'b0));
    foreach (seq[k]) begin
      @(negedge clk);
      check($sformatf("%s/c%0d", tag, k));
      $display("step %s cycle %0d state=%0d vec=%h", tag, k, bus.state, w_obs);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.op = 7'b0110011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b1; bus.zero = 1'b0;

    // Held in reset: FETCH values with all write enables masked
    @(negedge clk);
    exp_q.push_back(exp_out(4'd0, bus.op, bus.funct3, bus.funct7b5, bus.zero, 1'b1));
    check("reset_hold");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    run_instr("lw",       7'b0000011, 3'b010, 1'b0, 1'b0);
    run_instr("sw",       7'b0100011, 3'b010, 1'b0, 1'b0);
    run_instr("add",      7'b0110011, 3'b000, 1'b0, 1'b0);
    run_instr("sub",      7'b0110011, 3'b000, 1'b1, 1'b0);
    run_instr("and",      7'b0110011, 3'b111, 1'b0, 1'b0);
    run_instr("or",       7'b0110011, 3'b110, 1'b0, 1'b0);
    run_instr("slt",      7'b0110011, 3'b010, 1'b0, 1'b0);
    run_instr("addi_f7",  7'b0010011, 3'b000, 1'b1, 1'b0);
    run_instr("ori",      7'b0010011, 3'b110, 1'b0, 1'b1);
    run_instr("beq_t",    7'b1100011, 3'b000, 1'b0, 1'b1);
    run_instr("beq_nt",   7'b1100011, 3'b000, 1'b0, 1'b0);
    run_instr("bne_t",    7'b1100011, 3'b001, 1'b0, 1'b0);
    run_instr("bne_nt",   7'b1100011, 3'b001, 1'b0, 1'b1);
    run_instr("blt_ill",  7'b1100011, 3'b100, 1'b0, 1'b1);
    run_instr("jal",      7'b1101111, 3'b000, 1'b0, 1'b0);
    run_instr("lui_ill",  7'b0110111, 3'b000, 1'b0, 1'b0);
    run_instr("jalr_ill", 7'b1100111, 3'b000, 1'b0, 1'b0);

    // Reset asserted mid-load while in MEMREAD
    bus.op = 7'b0000011; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
    for (int k = 0; k < 4; k++) exp_q.push_back(exp_out(4'(k), bus.op, 3'b010, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("lw_rst/c%0d", k));
      $display("step lw_rst cycle %0d state=%0d vec=%h", k, bus.state, w_obs);
      if (k < 3) begin @(posedge clk); #1; end
    end
    rst_n = 1'b0;
    #1;
    exp_q.push_back(exp_out(4'd3, bus.op, 3'b010, 1'b0, 1'b0, 1'b1));
    check("rst_mid_comb");
    @(posedge clk); #1;
    @(negedge clk);
    exp_q.push_back(exp_out(4'd4, bus.op, 3'b010, 1'b0, 1'b0, 1'b1));
    check("rst_mid_hold");
    $display("step rst_mid hold state=%0d vec=%h", bus.state, w_obs);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Out of reset the register must be in FETCH, not MEMWB
    run_instr("lui_after_rst", 7'b0110111, 3'b000, 1'b0, 1'b0);
    run_instr("sw_after_rst",  7'b0100011, 3'b000, 1'b0, 1'b0);

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
